// File: rtl/channel_sum4_reducer.sv
// -----------------------------------------------------------------------------
// channel_sum4_reducer
//
// Purpose:
//   Reads COUNT words from an input FIFO channel one at a time. Each word is
//   added into a WIDTH-bit accumulator that wraps modulo 2^WIDTH. The final
//   sum is written once to an output FIFO channel. After that write the
//   block raises `valid` and holds it until the next reset.
//
// Handshake semantics (both channels):
//   Input channel:
//     - in_read_ready = 1 means the channel holds a word.
//     - The engine samples in_read_ready only while waiting for data.
//     - When it is seen high, the engine issues a one-cycle in_read_valid
//       pulse on the following cycle.
//     - The word on in_out_data is captured in the cycle after that pulse.
//   Output channel:
//     - out_write_ready = 1 means the channel can take a word.
//     - The engine samples out_write_ready only while waiting to write.
//     - When it is seen high, the engine drives out_write_valid = all ones
//       and out_in_data = sum for exactly one cycle on the following cycle.
//   Ready inputs are ignored in every other state.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   valid             done flag, high from the DONE state onward
//   in_in_data        constant 0 (the block never writes the input channel)
//   in_read_valid     read strobe to the input channel
//   in_rst            constant 0
//   in_write_valid    constant 0
//   in_out_data       data word from the input channel
//   in_read_ready     input channel has data
//   in_write_ready    unused
//   out_in_data       sum presented to the output channel during WRITE
//   out_read_valid    constant 0
//   out_rst           constant 0
//   out_write_valid   write strobe, all ones during WRITE
//   out_out_data      unused
//   out_read_ready    unused
//   out_write_ready   output channel can accept a word
//   dbg_state_o       current FSM state, for observation only
// -----------------------------------------------------------------------------
module channel_sum4_reducer #(
  parameter int WIDTH = 32,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             valid,
  output logic [WIDTH-1:0] in_in_data,
  output logic             in_read_valid,
  output logic             in_rst,
  output logic [WIDTH-1:0] in_write_valid,
  input  logic [WIDTH-1:0] in_out_data,
  input  logic             in_read_ready,
  input  logic             in_write_ready,
  output logic [WIDTH-1:0] out_in_data,
  output logic             out_read_valid,
  output logic             out_rst,
  output logic [WIDTH-1:0] out_write_valid,
  input  logic [WIDTH-1:0] out_out_data,
  input  logic             out_read_ready,
  input  logic             out_write_ready,
  output logic [3:0]       dbg_state_o
);

  typedef enum logic [3:0] {
    S_INIT       = 4'd0,
    S_LOOP_ENTRY = 4'd1,
    S_WAIT_IN    = 4'd2,
    S_STROBE     = 4'd3,
    S_ACCUM      = 4'd4,
    S_BRANCH     = 4'd5,
    S_WAIT_OUT   = 4'd6,
    S_WRITE      = 4'd7,
    S_DONE       = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] i_q, i_d;
  logic [WIDTH-1:0] i_next_q, i_next_d;
  logic             exit_q, exit_d;

  // Unused channel inputs are gathered here so their absence of loads is explicit.
  logic unused_inputs;
  assign unused_inputs = in_write_ready ^ out_read_ready ^ (^out_out_data);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_INIT;
      sum_q    <= '0;
      i_q      <= '0;
      i_next_q <= '0;
      exit_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      i_q      <= i_d;
      i_next_q <= i_next_d;
      exit_q   <= exit_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    i_d      = i_q;
    i_next_d = i_next_q;
    exit_d   = exit_q;
    unique case (state_q)
      S_INIT: begin
        sum_d   = '0;
        state_d = S_LOOP_ENTRY;
      end
      S_LOOP_ENTRY: begin
        i_d     = '0;
        state_d = S_WAIT_IN;
      end
      S_WAIT_IN: begin
        if (in_read_ready) begin
          // The loop-exit compare is resolved here, one word ahead of the
          // branch, so that BRANCH only has to move a flag.
          i_next_d = i_q + 1'b1;
          exit_d   = ((i_q + 1'b1) == WIDTH'(COUNT));
          state_d  = S_STROBE;
        end
      end
      S_STROBE: state_d = S_ACCUM;
      S_ACCUM: begin
        // The channel presents the word in the cycle after the read strobe.
        sum_d   = sum_q + in_out_data;
        state_d = S_BRANCH;
      end
      S_BRANCH: begin
        i_d     = i_next_q;
        state_d = exit_q ? S_WAIT_OUT : S_WAIT_IN;
      end
      S_WAIT_OUT: begin
        if (out_write_ready) state_d = S_WRITE;
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_INIT;
    endcase
  end

  // Output decode: pure function of state and sum, no output registers.
  always_comb begin
    valid           = 1'b0;
    in_read_valid   = 1'b0;
    out_write_valid = '0;
    out_in_data     = '0;
    unique case (state_q)
      S_STROBE: in_read_valid = 1'b1;
      S_WRITE: begin
        out_write_valid = '1;
        out_in_data     = sum_q;
      end
      S_DONE:  valid = 1'b1;
      default: ;
    endcase
  end

  assign in_in_data     = '0;
  assign in_rst         = 1'b0;
  assign in_write_valid = '0;
  assign out_read_valid = 1'b0;
  assign out_rst        = 1'b0;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_channel_sum4_reducer.sv
// -----------------------------------------------------------------------------
// Testbench for channel_sum4_reducer.
//
// Structure:
//   - The input channel is a word queue. Each in_read_valid pulse pops the
//     next word onto in_out_data.
//   - Every reduction pushes its expected sum into exp_q. The expected sum
//     is the plain modulo-2^32 sum of the four words.
//   - The monitor pops exp_q on every write strobe.
//   - Ready inputs are driven either by a cycle-window stall schedule or
//     randomly.
// -----------------------------------------------------------------------------
module tb_channel_sum4_reducer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid;
  logic [W-1:0] in_in_data;
  logic         in_read_valid;
  logic         in_rst;
  logic [W-1:0] in_write_valid;
  logic [W-1:0] in_out_data = '0;
  logic         in_read_ready;
  logic         in_write_ready = 1'b0;
  logic [W-1:0] out_in_data;
  logic         out_read_valid;
  logic         out_rst;
  logic [W-1:0] out_write_valid;
  logic [W-1:0] out_out_data = '0;
  logic         out_read_ready = 1'b0;
  logic         out_write_ready;
  logic [3:0]   dbg_state;

  channel_sum4_reducer #(.WIDTH(W), .COUNT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid           (valid),
    .in_in_data      (in_in_data),
    .in_read_valid   (in_read_valid),
    .in_rst          (in_rst),
    .in_write_valid  (in_write_valid),
    .in_out_data     (in_out_data),
    .in_read_ready   (in_read_ready),
    .in_write_ready  (in_write_ready),
    .out_in_data     (out_in_data),
    .out_read_valid  (out_read_valid),
    .out_rst         (out_rst),
    .out_write_valid (out_write_valid),
    .out_out_data    (out_out_data),
    .out_read_ready  (out_read_ready),
    .out_write_ready (out_write_ready),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc;  // cycles since reset release; cycle 0 is INIT
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- scoreboard state ----------------
  int           checks    = 0;
  int           failures  = 0;
  logic [W-1:0] in_q[$];
  logic [W-1:0] exp_q[$];
  int           exp_cyc   = -1;
  int           write_cnt = 0;
  int           read_cnt  = 0;
  logic         wrote     = 1'b0;

  // ---------------- ready driver ----------------
  int rdy_mode = 0;  // 0: stall windows, 1: random
  int in_lo = -1, in_hi = -1, out_lo = -1, out_hi = -1;

  initial begin
    in_read_ready   = 1'b0;
    out_write_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rdy_mode == 1) begin
        in_read_ready   = 1'($urandom_range(0, 1));
        out_write_ready = 1'($urandom_range(0, 1));
      end else begin
        in_read_ready   = !(cyc >= in_lo && cyc < in_hi);
        out_write_ready = !(cyc >= out_lo && cyc < out_hi);
      end
    end
  end

  // ---------------- monitor / input channel model ----------------
  always @(negedge clk) begin
    if (rst) begin
      in_q.delete();
      exp_q.delete();
      wrote = 1'b0;
    end else begin
      checks++;
      if (valid !== wrote) begin
        failures++;
        $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, valid, wrote);
      end
      checks++;
      if ({in_in_data, in_rst, in_write_valid, out_read_valid, out_rst} !== '0) begin
        failures++;
        $display("FAIL const_outs cyc=%0d got=%h exp=0", cyc,
                 {in_in_data, in_rst, in_write_valid, out_read_valid, out_rst});
      end
      if (in_read_valid === 1'b1) begin
        read_cnt++;
        checks++;
        if (in_q.size() == 0) begin
          failures++;
          $display("FAIL extra_read cyc=%0d got=read_strobe exp=no_strobe", cyc);
        end else begin
          in_out_data = in_q.pop_front();
        end
      end
      if (out_write_valid !== '0) begin
        write_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_write cyc=%0d got=%h exp=no_write", cyc, out_in_data);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (out_in_data !== e) begin
            failures++;
            $display("FAIL sum cyc=%0d got=%h exp=%h", cyc, out_in_data, e);
          end
          checks++;
          if (out_write_valid !== '1) begin
            failures++;
            $display("FAIL wstrobe cyc=%0d got=%h exp=ffffffff", cyc, out_write_valid);
          end
          if (exp_cyc >= 0) begin
            checks++;
            if (cyc != exp_cyc) begin
              failures++;
              $display("FAIL write_cycle got=%0d exp=%0d", cyc, exp_cyc);
            end
          end
        end
        wrote = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic push_words(input logic [W-1:0] w0, input logic [W-1:0] w1,
                            input logic [W-1:0] w2, input logic [W-1:0] w3);
    logic [W-1:0] s;
    in_q.push_back(w0);
    in_q.push_back(w1);
    in_q.push_back(w2);
    in_q.push_back(w3);
    s = w0 + w1 + w2 + w3;  // modulo 2^32 by truncation
    exp_q.push_back(s);
  endtask

  task automatic run(input logic [W-1:0] w0, input logic [W-1:0] w1,
                     input logic [W-1:0] w2, input logic [W-1:0] w3,
                     input int expc, input string name);
    int wstart, rstart;
    apply_reset();
    exp_cyc = expc;
    wstart  = write_cnt;
    rstart  = read_cnt;
    push_words(w0, w1, w2, w3);
    for (int k = 0; k < 300 && write_cnt == wstart; k++) @(negedge clk);
    checks++;
    if (write_cnt == wstart) begin
      failures++;
      $display("FAIL timeout_%s got=no_write exp=write", name);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (read_cnt - rstart != 4) begin
      failures++;
      $display("FAIL reads_%s got=%0d exp=4", name, read_cnt - rstart);
    end
    checks++;
    if (write_cnt - wstart != 1) begin
      failures++;
      $display("FAIL writes_%s got=%0d exp=1", name, write_cnt - wstart);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wstart;
    rdy_mode = 0;

    // Reset state.
    #3;
    checks++;
    if ({valid, in_read_valid, out_write_valid, out_in_data} !== '0) begin
      failures++;
      $display("FAIL reset_outs got=%h exp=0", {valid, in_read_valid, out_write_valid, out_in_data});
    end

    // Basic reduction, no stalls.
    run(32'd1, 32'd2, 32'd3, 32'd4, 19, "basic");

    // Input stall for five cycles before the second word.
    in_lo = 6; in_hi = 11;
    run(32'd1, 32'd2, 32'd3, 32'd4, 24, "in_stall");
    in_lo = -1; in_hi = -1;

    // Wrap-around.
    run(32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 19, "wrap");

    // Output stall for three cycles in WAIT_OUT.
    out_lo = 18; out_hi = 21;
    run(32'h1234_5678, 32'h1111_1111, 32'hF000_0000, 32'h0000_0001, 22, "out_stall");
    out_lo = -1; out_hi = -1;

    // Asynchronous reset during iteration 2, on the read-strobe cycle.
    apply_reset();
    exp_cyc = -1;
    push_words(32'd1, 32'd2, 32'd3, 32'd4);
    for (int k = 0; k < 100 && cyc != 11; k++) @(negedge clk);
    checks++;
    if (in_read_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_strobe got=%b exp=1", in_read_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({valid, in_read_valid, out_write_valid, out_in_data} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", {valid, in_read_valid, out_write_valid, out_in_data});
    end
    run(32'd5, 32'd5, 32'd5, 32'd5, 19, "after_reset");

    // Quiescence in DONE while the readies toggle.
    wstart   = write_cnt;
    rdy_mode = 1;
    repeat (50) @(negedge clk);
    checks++;
    if (write_cnt != wstart) begin
      failures++;
      $display("FAIL done_quiet got=%0d exp=%0d", write_cnt, wstart);
    end

    // Random words with random ready behaviour.
    for (int t = 0; t < 6; t++) begin
      run($urandom, $urandom, $urandom, $urandom, -1, "random");
    end

    rdy_mode = 0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
